// File: rtl/rca_pkg.sv
// Shared defaults and result/counter types for the ripple-carry-adder result collector.
package rca_pkg;

  localparam int NBITS_DEF = 8;
  localparam int RES_W     = NBITS_DEF + 1;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic                 cout;
    logic [NBITS_DEF-1:0] sum;
  } rca_result_t;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/rca_sync_fifo.sv
// Synchronous FIFO with count; caller must not push when full nor pop when empty.
module rca_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rca_result_collector.sv
// Collects {cout,sum} from the pipelined ripple-carry adder using a latency-matched valid delay line.
// Optional operand self-check is enabled by defining RCA_SELFCHECK_EN.
module rca_result_collector
  import rca_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int ADDER_LAT  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  input  logic             in_cin,
  input  logic [NBITS-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS:0]   out_data,
  output logic [CNT_W-1:0] result_cnt,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             chk_err
);

  localparam int RW   = NBITS + 1;
  localparam int FC_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W = $clog2(ADDER_LAT + 1);
  localparam int CR_W = $clog2(FIFO_DEPTH + ADDER_LAT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ADDER_LAT-1:0] vld_q, vld_d;
  logic [IF_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]     result_cnt_q, result_cnt_d;
  logic [CNT_W-1:0]     carry_cnt_q, carry_cnt_d;
  logic                 accept, capture, pop;
  logic                 fifo_full, fifo_empty;
  logic [FC_W-1:0]      fifo_count;
  logic [RW-1:0]        cap_data, head;

  // Credit covers both queued and still-in-adder results, so a capture always finds room.
  assign in_ready  = (CR_W'(fifo_count) + CR_W'(inflight_q)) < CR_W'(FIFO_DEPTH);
  assign accept    = in_valid & in_ready;
  assign capture   = vld_q[ADDER_LAT-1];
  assign cap_data  = {add_cout, add_sum};
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign out_data  = fifo_empty ? '0 : head;

  always_comb begin
    vld_d        = vld_q << 1;
    vld_d[0]     = accept;
    inflight_d   = inflight_q;
    result_cnt_d = result_cnt_q;
    carry_cnt_d  = carry_cnt_q;
    if (accept && !capture)      inflight_d = inflight_q + 1'b1;
    else if (!accept && capture) inflight_d = inflight_q - 1'b1;
    if (capture) begin
      result_cnt_d = sat_inc(result_cnt_q);
      if (add_cout) carry_cnt_d = sat_inc(carry_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      inflight_q   <= '0;
      result_cnt_q <= '0;
      carry_cnt_q  <= '0;
    end else begin
      vld_q        <= vld_d;
      inflight_q   <= inflight_d;
      result_cnt_q <= result_cnt_d;
      carry_cnt_q  <= carry_cnt_d;
    end
  end

  assign result_cnt = result_cnt_q;
  assign carry_cnt  = carry_cnt_q;

  rca_sync_fifo #(
    .WIDTH(RW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (capture & ~fifo_full),
    .din  (cap_data),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

`ifdef RCA_SELFCHECK_EN
  logic [NBITS-1:0]     a_q [ADDER_LAT];
  logic [NBITS-1:0]     a_d [ADDER_LAT];
  logic [NBITS-1:0]     b_q [ADDER_LAT];
  logic [NBITS-1:0]     b_d [ADDER_LAT];
  logic [ADDER_LAT-1:0] cin_q, cin_d;
  logic [RW-1:0]        exp_res;
  logic                 chk_err_q, chk_err_d;

  always_comb begin
    a_d[0]   = in_a;
    b_d[0]   = in_b;
    cin_d    = cin_q << 1;
    cin_d[0] = in_cin;
    for (int i = 1; i < ADDER_LAT; i++) begin
      a_d[i] = a_q[i-1];
      b_d[i] = b_q[i-1];
    end
    exp_res   = RW'(a_q[ADDER_LAT-1]) + RW'(b_q[ADDER_LAT-1]) + RW'(cin_q[ADDER_LAT-1]);
    chk_err_d = chk_err_q | (capture & (cap_data != exp_res));
  end

  // Operand copies travel alongside the valid bit and need no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    cin_q <= cin_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`else
  logic unused_ops;
  assign unused_ops = ^{in_a, in_b, in_cin};
  assign chk_err    = 1'b0;
`endif

endmodule
